// File: rtl/store_checker.sv
`default_nettype none
// ============================================================================
// Module   : store_checker
// Purpose  : Compares core data-memory stores against a loadable table of
//            expected stores and reports a pass/fail/timeout verdict.
//            Optional macro STORE_CHECKER_FILTER_EN ignores stores outside
//            the (FILTER_MASK, FILTER_BASE) address window.
// Revision : 1.0 - initial release
// ============================================================================
module store_checker #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DEPTH       = 8,
    parameter int                    MAX_CYCLES  = 200,
    parameter int                    ORDERED     = 1,
    parameter logic [ADDR_WIDTH-1:0] FILTER_BASE = '0,
    parameter logic [ADDR_WIDTH-1:0] FILTER_MASK = '0
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              MemWrite,
    input  logic [ADDR_WIDTH-1:0]             DataAdr,
    input  logic [DATA_WIDTH-1:0]             WriteData,
    input  logic                              exp_we,
    input  logic [$clog2(DEPTH)-1:0]          exp_idx,
    input  logic [ADDR_WIDTH-1:0]             exp_adr,
    input  logic [DATA_WIDTH-1:0]             exp_data,
    input  logic [$clog2(DEPTH):0]            exp_count,
    input  logic                              start,
    output logic                              done,
    output logic                              pass,
    output logic                              fail,
    output logic                              timeout,
    output logic [$clog2(DEPTH):0]            match_count,
    output logic [$clog2(MAX_CYCLES+1)-1:0]   cycle_count,
    output logic [ADDR_WIDTH-1:0]             err_adr,
    output logic [DATA_WIDTH-1:0]             err_data
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;
    localparam int CYC_W = $clog2(MAX_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RUN     = 3'd1,
        S_PASS    = 3'd2,
        S_FAIL    = 3'd3,
        S_TIMEOUT = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [ADDR_WIDTH-1:0]  r_tab_adr  [DEPTH];
    logic [DATA_WIDTH-1:0]  r_tab_data [DEPTH];
    logic [DEPTH-1:0]       r_hit;
    logic [CNT_W-1:0]       r_count;
    logic [CNT_W-1:0]       r_match;
    logic [CYC_W-1:0]       r_cycle;
    logic [ADDR_WIDTH-1:0]  r_err_adr;
    logic [DATA_WIDTH-1:0]  r_err_data;
    logic                   r_done;
    logic                   r_pass;
    logic                   r_fail;
    logic                   r_timeout;

    logic                   w_in_window;
    logic                   w_store;
    logic                   w_match;
    logic [DEPTH-1:0]       w_hit_set;
    logic [CNT_W-1:0]       w_match_nxt;
    logic [CYC_W-1:0]       w_cycle_nxt;

`ifdef STORE_CHECKER_FILTER_EN
    assign w_in_window = ((DataAdr & FILTER_MASK) == FILTER_BASE);
`else
    // Filter window parameters are inert in this build; window always open.
    logic w_unused_filter;
    assign w_unused_filter = ^{FILTER_BASE, FILTER_MASK};
    assign w_in_window     = 1'b1;
`endif

    assign w_store     = MemWrite & w_in_window;
    assign w_match_nxt = r_match + CNT_W'(1);
    assign w_cycle_nxt = r_cycle + CYC_W'(1);

    generate
        if (ORDERED != 0) begin : g_ordered
            logic [IDX_W-1:0] w_idx;
            assign w_idx     = r_match[IDX_W-1:0];
            assign w_match   = (r_tab_adr[w_idx] == DataAdr) &&
                               (r_tab_data[w_idx] == WriteData);
            assign w_hit_set = '0;
        end else begin : g_unordered
            logic [DEPTH-1:0] w_cand;
            for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cand
                assign w_cand[gi] = (CNT_W'(gi) < r_count) && !r_hit[gi] &&
                                    (r_tab_adr[gi] == DataAdr) &&
                                    (r_tab_data[gi] == WriteData);
            end
            assign w_match   = |w_cand;
            // Isolate the lowest free matching entry so duplicates stay available.
            assign w_hit_set = w_cand & (~w_cand + DEPTH'(1));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = (exp_count == '0) ? S_PASS : S_RUN;
                end
            end
            S_RUN: begin
                // Mismatch outranks timeout; a completing match outranks timeout.
                if (w_store && !w_match) begin
                    w_state_nxt = S_FAIL;
                end else if (w_store && (w_match_nxt == r_count)) begin
                    w_state_nxt = S_PASS;
                end else if (w_cycle_nxt == CYC_W'(MAX_CYCLES)) begin
                    w_state_nxt = S_TIMEOUT;
                end
            end
            default: w_state_nxt = r_state;
        endcase
    end

    // Expected-store table; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if ((r_state == S_IDLE) && exp_we) begin
            r_tab_adr[exp_idx]  <= exp_adr;
            r_tab_data[exp_idx] <= exp_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hit      <= '0;
            r_count    <= '0;
            r_match    <= '0;
            r_cycle    <= '0;
            r_err_adr  <= '0;
            r_err_data <= '0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_fail     <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_count <= exp_count;
                        r_hit   <= '0;
                    end
                end
                S_RUN: begin
                    r_cycle <= w_cycle_nxt;
                    if (w_store) begin
                        if (w_match) begin
                            r_match <= w_match_nxt;
                            r_hit   <= r_hit | w_hit_set;
                        end else begin
                            r_err_adr  <= DataAdr;
                            r_err_data <= WriteData;
                        end
                    end
                end
                default: ;
            endcase
            r_pass    <= (w_state_nxt == S_PASS);
            r_fail    <= (w_state_nxt == S_FAIL);
            r_timeout <= (w_state_nxt == S_TIMEOUT);
            r_done    <= (w_state_nxt == S_PASS) || (w_state_nxt == S_FAIL) ||
                         (w_state_nxt == S_TIMEOUT);
        end
    end

    assign done        = r_done;
    assign pass        = r_pass;
    assign fail        = r_fail;
    assign timeout     = r_timeout;
    assign match_count = r_match;
    assign cycle_count = r_cycle;
    assign err_adr     = r_err_adr;
    assign err_data    = r_err_data;

endmodule
`default_nettype wire

// File: tb/tb_store_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_store_checker
// Purpose  : Directed and randomized scenarios for store_checker, run on an
//            ordered and an unordered instance sharing the same stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_store_checker;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 8;
    localparam int MAXC  = 200;
    localparam int IW    = $clog2(DEPTH);
    localparam int CW    = IW + 1;
    localparam int YW    = $clog2(MAXC + 1);
    localparam int NRUN  = MAXC + 3;
    localparam logic [AW-1:0] FMASK = 32'hFFFF_FF00;
    localparam logic [AW-1:0] FBASE = 32'h0000_0000;
`ifdef STORE_CHECKER_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset = 1'b1;
    logic          MemWrite = 1'b0;
    logic [AW-1:0] DataAdr = '0;
    logic [DW-1:0] WriteData = '0;
    logic          exp_we = 1'b0;
    logic [IW-1:0] exp_idx = '0;
    logic [AW-1:0] exp_adr = '0;
    logic [DW-1:0] exp_data = '0;
    logic [CW-1:0] exp_count = '0;
    logic          start = 1'b0;

    logic          done_v [2];
    logic          pass_v [2];
    logic          fail_v [2];
    logic          tmo_v  [2];
    logic [CW-1:0] mc_v   [2];
    logic [YW-1:0] cyc_v  [2];
    logic [AW-1:0] ea_v   [2];
    logic [DW-1:0] ed_v   [2];

    store_checker #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .MAX_CYCLES(MAXC),
        .ORDERED(1), .FILTER_BASE(FBASE), .FILTER_MASK(FMASK)
    ) u_ord (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr),
        .WriteData(WriteData), .exp_we(exp_we), .exp_idx(exp_idx),
        .exp_adr(exp_adr), .exp_data(exp_data), .exp_count(exp_count),
        .start(start), .done(done_v[0]), .pass(pass_v[0]), .fail(fail_v[0]),
        .timeout(tmo_v[0]), .match_count(mc_v[0]), .cycle_count(cyc_v[0]),
        .err_adr(ea_v[0]), .err_data(ed_v[0])
    );

    store_checker #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .MAX_CYCLES(MAXC),
        .ORDERED(0), .FILTER_BASE(FBASE), .FILTER_MASK(FMASK)
    ) u_unord (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr),
        .WriteData(WriteData), .exp_we(exp_we), .exp_idx(exp_idx),
        .exp_adr(exp_adr), .exp_data(exp_data), .exp_count(exp_count),
        .start(start), .done(done_v[1]), .pass(pass_v[1]), .fail(fail_v[1]),
        .timeout(tmo_v[1]), .match_count(mc_v[1]), .cycle_count(cyc_v[1]),
        .err_adr(ea_v[1]), .err_data(ed_v[1])
    );

    int checks = 0;
    int errors = 0;

    // Scenario: expected-store table plus a time-ordered list of core stores.
    int            n;
    logic [AW-1:0] tab_adr [DEPTH];
    logic [DW-1:0] tab_dat [DEPTH];
    int            st_cyc [$];
    logic [AW-1:0] st_adr [$];
    logic [DW-1:0] st_dat [$];

    // Model results per flavour (0 ordered, 1 unordered); ev: 0 pass 1 fail 2 timeout.
    int            ev  [2];
    int            evc [2];
    logic [AW-1:0] eea [2];
    logic [DW-1:0] eed [2];
    bit            mok [2][64];

    task automatic chk(input string tag, input int f, input logic [31:0] obs,
                       input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s dut%0d: observed %0h expected %0h", tag, f, obs, expv);
        end
    endtask

    task automatic clear_stores();
        st_cyc.delete();
        st_adr.delete();
        st_dat.delete();
    endtask

    task automatic add_store(input int c, input logic [AW-1:0] a, input logic [DW-1:0] d);
        st_cyc.push_back(c);
        st_adr.push_back(a);
        st_dat.push_back(d);
    endtask

    task automatic model(input int f);
        bit used [DEPTH];
        int mc;
        int hit;
        mc = 0;
        ev[f] = 2; evc[f] = MAXC; eea[f] = '0; eed[f] = '0;
        for (int j = 0; j < DEPTH; j++) used[j] = 1'b0;
        for (int i = 0; i < 64; i++) mok[f][i] = 1'b0;
        if (n == 0) begin
            ev[f] = 0; evc[f] = 0;
            return;
        end
        for (int i = 0; i < st_cyc.size(); i++) begin
            if (st_cyc[i] > MAXC) break;
            if (FILT && ((st_adr[i] & FMASK) != FBASE)) continue;
            hit = -1;
            // Ordered: only the next unmatched entry qualifies; unordered: any free one.
            for (int j = 0; j < n; j++)
                if (hit < 0 && !used[j] && st_adr[i] == tab_adr[j] &&
                    st_dat[i] == tab_dat[j] && (f == 1 || j == mc))
                    hit = j;
            if (hit < 0) begin
                ev[f] = 1; evc[f] = st_cyc[i]; eea[f] = st_adr[i]; eed[f] = st_dat[i];
                return;
            end
            used[hit] = 1'b1;
            mok[f][i] = 1'b1;
            mc++;
            if (mc == n) begin
                ev[f] = 0; evc[f] = st_cyc[i];
                return;
            end
        end
    endtask

    task automatic check_at(input int k);
        for (int f = 0; f < 2; f++) begin
            bit dn;
            int mc;
            int cy;
            dn = (k >= evc[f]);
            mc = 0;
            for (int i = 0; i < st_cyc.size(); i++)
                if (mok[f][i] && st_cyc[i] <= k) mc++;
            cy = (k < evc[f]) ? k : evc[f];
            chk("done",        f, 32'(done_v[f]), 32'(dn));
            chk("pass",        f, 32'(pass_v[f]), 32'(dn && ev[f] == 0));
            chk("fail",        f, 32'(fail_v[f]), 32'(dn && ev[f] == 1));
            chk("timeout",     f, 32'(tmo_v[f]),  32'(dn && ev[f] == 2));
            chk("match_count", f, 32'(mc_v[f]),   32'(mc));
            chk("cycle_count", f, 32'(cyc_v[f]),  32'(cy));
            chk("err_adr",     f, ea_v[f], (dn && ev[f] == 1) ? eea[f] : 32'h0);
            chk("err_data",    f, ed_v[f], (dn && ev[f] == 1) ? eed[f] : 32'h0);
        end
    endtask

    task automatic check_zero(input string tag);
        for (int f = 0; f < 2; f++) begin
            chk({tag, "_done"},    f, 32'(done_v[f]), 32'h0);
            chk({tag, "_pass"},    f, 32'(pass_v[f]), 32'h0);
            chk({tag, "_fail"},    f, 32'(fail_v[f]), 32'h0);
            chk({tag, "_timeout"}, f, 32'(tmo_v[f]),  32'h0);
            chk({tag, "_match"},   f, 32'(mc_v[f]),   32'h0);
            chk({tag, "_cycle"},   f, 32'(cyc_v[f]),  32'h0);
            chk({tag, "_err_adr"}, f, ea_v[f],        32'h0);
            chk({tag, "_err_dat"}, f, ed_v[f],        32'h0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; MemWrite = 1'b0; start = 1'b0; exp_we = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_zero("rst");
        reset = 1'b0;
    endtask

    // Load the table, start (last entry written alongside start), then run
    // NRUN cycles checking every output against the model after each edge.
    task automatic run_case(input int rst_at);
        int p;
        model(0);
        model(1);
        do_reset();
        for (int j = 0; j < n - 1; j++) begin
            exp_we = 1'b1; exp_idx = IW'(j); exp_adr = tab_adr[j]; exp_data = tab_dat[j];
            MemWrite = 1'($urandom_range(0, 1)); DataAdr = $urandom; WriteData = $urandom;
            @(negedge clk);
        end
        start = 1'b1; exp_count = CW'(n);
        MemWrite = 1'($urandom_range(0, 1)); DataAdr = $urandom; WriteData = $urandom;
        exp_we = (n > 0);
        if (n > 0) begin
            exp_idx = IW'(n - 1); exp_adr = tab_adr[n-1]; exp_data = tab_dat[n-1];
        end
        @(negedge clk);
        start = 1'b0; exp_we = 1'b0;
        p = 0;
        for (int k = 0; k <= NRUN; k++) begin
            if (k == rst_at) begin
                reset = 1'b1; MemWrite = 1'b0; start = 1'b0; exp_we = 1'b0;
                @(negedge clk);
                check_zero("abort");
                reset = 1'b0;
                return;
            end
            check_at(k);
            if (p < st_cyc.size() && st_cyc[p] == k + 1) begin
                MemWrite = 1'b1; DataAdr = st_adr[p]; WriteData = st_dat[p];
                p++;
            end else begin
                MemWrite = 1'b0; DataAdr = $urandom; WriteData = $urandom;
            end
            // Table writes, restarts and count changes must not disturb a run.
            start     = ($urandom_range(0, 7) == 0);
            exp_we    = ($urandom_range(0, 3) == 0);
            exp_idx   = IW'($urandom);
            exp_adr   = $urandom;
            exp_data  = $urandom;
            exp_count = CW'($urandom);
            @(negedge clk);
        end
    endtask

    initial begin
        int ord [$];
        int c;
        int mode;
        int tmp;
        int r;

        do_reset();

        // Ordered single entry matched at RUN cycle 40.
        n = 1; tab_adr[0] = 32'd100; tab_dat[0] = 32'd25;
        clear_stores(); add_store(40, 32'd100, 32'd25);
        run_case(-1);
        chk("tp1_pass", 0, 32'(pass_v[0]), 32'h1);
        chk("tp1_mc",   0, 32'(mc_v[0]),   32'h1);

        // Out-of-order pair: ordered fails on the first store, unordered passes.
        n = 2; tab_adr[1] = 32'd104; tab_dat[1] = 32'd7;
        clear_stores(); add_store(5, 32'd104, 32'd7); add_store(8, 32'd100, 32'd25);
        run_case(-1);
        chk("tp2_fail", 0, 32'(fail_v[0]), 32'h1);
        chk("tp2_eadr", 0, ea_v[0],        32'd104);
        chk("tp2_edat", 0, ed_v[0],        32'd7);
        chk("tp2_mc",   0, 32'(mc_v[0]),   32'h0);
        chk("tp3_pass", 1, 32'(pass_v[1]), 32'h1);

        // Same store twice: second one has no free entry.
        clear_stores(); add_store(5, 32'd100, 32'd25); add_store(9, 32'd100, 32'd25);
        run_case(-1);
        chk("tp3_dup_fail", 1, 32'(fail_v[1]), 32'h1);
        chk("tp3_dup_mc",   1, 32'(mc_v[1]),   32'h1);

        // No stores: timeout with cycle_count at the limit.
        clear_stores();
        run_case(-1);
        chk("tp4_tmo", 0, 32'(tmo_v[0]), 32'h1);
        chk("tp4_cyc", 0, 32'(cyc_v[0]), 32'(MAXC));

        // Completing store on the timeout cycle wins.
        clear_stores(); add_store(50, 32'd100, 32'd25); add_store(MAXC, 32'd104, 32'd7);
        run_case(-1);
        chk("tp5_pass", 0, 32'(pass_v[0]), 32'h1);
        chk("tp5_tmo",  0, 32'(tmo_v[0]),  32'h0);
        chk("tp5_cyc",  1, 32'(cyc_v[1]),  32'(MAXC));

        // Reset at RUN cycle 10 after one match, then a clean rerun.
        clear_stores(); add_store(5, 32'd100, 32'd25); add_store(30, 32'd104, 32'd7);
        run_case(10);
        run_case(-1);
        chk("tp6_pass", 0, 32'(pass_v[0]), 32'h1);

        // Out-of-window store: ignored with the filter, a mismatch without it.
        n = 1;
        clear_stores(); add_store(3, 32'h200, 32'd99); add_store(6, 32'd100, 32'd25);
        run_case(-1);
        chk("tp7_pass", 0, 32'(pass_v[0]), FILT ? 32'h1 : 32'h0);
        chk("tp7_eadr", 0, ea_v[0],        FILT ? 32'h0 : 32'h200);

        for (int s = 0; s < 24; s++) begin
            n = $urandom_range(0, DEPTH);
            for (int j = 0; j < DEPTH; j++) begin
                tab_adr[j] = 32'($urandom_range(0, 63)) << 2;
                tab_dat[j] = $urandom;
            end
            mode = $urandom_range(0, 4);
            ord.delete();
            for (int j = 0; j < n; j++) ord.push_back(j);
            if (mode == 1 || mode == 4) begin
                for (int j = ord.size() - 1; j > 0; j--) begin
                    r = $urandom_range(0, j);
                    tmp = ord[j]; ord[j] = ord[r]; ord[r] = tmp;
                end
            end
            if (mode == 3 && n > 0) void'(ord.pop_back());
            if (mode == 4 && n > 0) ord.insert($urandom_range(0, ord.size()), ord[$urandom_range(0, n - 1)]);
            clear_stores();
            c = 0;
            for (int i = 0; i < ord.size(); i++) begin
                if ($urandom_range(0, 7) == 0) begin
                    c += $urandom_range(1, 10);
                    add_store(c, 32'h300 | 32'($urandom_range(0, 255)), $urandom);
                end
                c += $urandom_range(1, 30);
                add_store(c, tab_adr[ord[i]], tab_dat[ord[i]]);
            end
            if (mode == 2 && st_cyc.size() > 0) begin
                r = $urandom_range(0, st_cyc.size() - 1);
                st_dat[r] = st_dat[r] ^ (32'h1 << $urandom_range(0, 31));
            end
            run_case(-1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
